// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg: shared types and parameter defaults for the hazard/stall unit.
//   hz_state_t       : pipeline-control FSM states (RUN, MEM_WAIT, ERROR)
//   DEF_MEM_TIMEOUT  : default MEM_WAIT cycle limit before the error trap
//   DEF_CNT_W        : default width of the performance counters
package hazard_pkg;

  localparam int unsigned DEF_MEM_TIMEOUT = 255;
  localparam int unsigned DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: synchronous saturating up-counter.
//   clk   : clock, rising edge
//   clear : synchronous clear, has priority over inc
//   inc   : count up by one unless already all-ones
//   q     : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline hazard detection and stall/flush control.
// Detects load-use hazards, taken branches and slow data-memory accesses,
// and drives the stage-register enables / NOP-insert controls.
//   clk, rst                               : clock, synchronous active-high reset
//   rs1IFID, rs2IFID, useRs1IFID, useRs2IFID : IF/ID source operands
//   rdIDEX, MemReadIDEX                    : ID/EX destination and load flag
//   branchTakenEX                          : taken branch resolved in EX
//   dmemReqEXMEM, dmemReady                : data-memory handshake
//   pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite : stage enables
//   IFIDFlush, IDEXBubble, MEMWBBubble     : NOP insertion
//   memError                               : sticky memory-timeout flag
//   stallCount, flushCount                 : saturating perf counters
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1IFID,
  input  logic [4:0]       rs2IFID,
  input  logic             useRs1IFID,
  input  logic             useRs2IFID,
  input  logic [4:0]       rdIDEX,
  input  logic             MemReadIDEX,
  input  logic             branchTakenEX,
  input  logic             dmemReqEXMEM,
  input  logic             dmemReady,
  output logic             pcWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             MEMWBBubble,
  output logic             memError,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         r_state;
  hz_state_t         w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_load_use;
  logic              w_mem_busy;
  logic              w_freeze;

  assign w_load_use = MemReadIDEX && (rdIDEX != 5'd0) &&
                      ((useRs1IFID && (rdIDEX == rs1IFID)) ||
                       (useRs2IFID && (rdIDEX == rs2IFID)));

  assign w_mem_busy = dmemReqEXMEM && !dmemReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == RUN && w_next_state == MEM_WAIT) begin
        r_wait_cnt <= '0;
      end else if (r_state == MEM_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // The cycle that starts a wait is frozen in RUN already; the ready cycle in
  // MEM_WAIT is not frozen, so branch/load-use rules apply there.
  always_comb begin
    w_next_state = r_state;
    w_freeze     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_next_state = MEM_WAIT;
          w_freeze     = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmemReady) begin
          w_next_state = RUN;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == TIMEOUT_V) begin
            w_next_state = ERROR;
          end
        end
      end
      ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  always_comb begin
    pcWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    MEMWBBubble = 1'b0;
    if (rst) begin
      pcWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      MEMWBBubble = 1'b1;
    end else if (w_freeze) begin
      pcWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (branchTakenEX) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (w_load_use) begin
      pcWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  assign memError = (r_state == ERROR) && !rst;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (!rst && !pcWrite),
    .q     (stallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (IFIDFlush),
    .q     (flushCount)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1IFID = '0, rs2IFID = '0, rdIDEX = '0;
  logic       useRs1IFID = 1'b0, useRs2IFID = 1'b0, MemReadIDEX = 1'b0;
  logic       branchTakenEX = 1'b0, dmemReqEXMEM = 1'b0, dmemReady = 1'b0;
  logic       pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic       IFIDFlush, IDEXBubble, MEMWBBubble, memError;
  logic [3:0] stallCount, flushCount;

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1IFID(rs1IFID), .rs2IFID(rs2IFID),
    .useRs1IFID(useRs1IFID), .useRs2IFID(useRs2IFID),
    .rdIDEX(rdIDEX), .MemReadIDEX(MemReadIDEX),
    .branchTakenEX(branchTakenEX),
    .dmemReqEXMEM(dmemReqEXMEM), .dmemReady(dmemReady),
    .pcWrite(pcWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
    .MEMWBBubble(MEMWBBubble), .memError(memError),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  // {pcWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXBubble,MEMWBBubble}
  localparam logic [6:0] RST_C = 7'b0000_111;
  localparam logic [6:0] FRZ_C = 7'b0000_001;
  localparam logic [6:0] BR_C  = 7'b1111_110;
  localparam logic [6:0] LU_C  = 7'b0011_010;
  localparam logic [6:0] NRM_C = 7'b1111_000;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s.%s: got %0h want %0h", nm, fld, act, want);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  logic [15:0] m_e;
  string       m_nm;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      cmp(m_nm, "ctl", {1'b0, pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                        IFIDFlush, IDEXBubble, MEMWBBubble}, {1'b0, m_e[15:9]});
      cmp(m_nm, "memError", {7'd0, memError}, {7'd0, m_e[8]});
      cmp(m_nm, "stallCount", {4'd0, stallCount}, {4'd0, m_e[7:4]});
      cmp(m_nm, "flushCount", {4'd0, flushCount}, {4'd0, m_e[3:0]});
    end
  end

  // One cycle: drive inputs just after the edge and queue expected outputs
  // (counters are the values held during this cycle).
  task automatic vec(input string nm, input logic r,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic br,
                     input logic req, input logic rdy,
                     input logic [6:0] ctl, input logic me,
                     input logic [3:0] sc, input logic [3:0] fc);
    @(posedge clk);
    #1;
    rst = r; rs1IFID = s1; rs2IFID = s2; useRs1IFID = u1; useRs2IFID = u2;
    rdIDEX = rd; MemReadIDEX = mr; branchTakenEX = br;
    dmemReqEXMEM = req; dmemReady = rdy;
    name_q.push_back(nm);
    exp_q.push_back({ctl, me, sc, fc});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //   name        rst s1 s2 u1 u2 rd mr br rq rdy  ctl   me sc  fc
    vec("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_C, 0, 0, 0);
    vec("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 0, 0);
    vec("lu_rs1",     0, 5, 0, 1, 0, 5, 1, 0, 0, 0, LU_C,  0, 0, 0);
    vec("after_lu",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 1, 0);
    vec("lu_rd0",     0, 0, 0, 1, 0, 0, 1, 0, 0, 0, NRM_C, 0, 1, 0);
    vec("lu_nouse",   0, 5, 0, 0, 0, 5, 1, 0, 0, 0, NRM_C, 0, 1, 0);
    vec("lu_rs2",     0, 0, 7, 0, 1, 7, 1, 0, 0, 0, LU_C,  0, 1, 0);
    vec("noload",     0, 5, 0, 1, 0, 5, 0, 0, 0, 0, NRM_C, 0, 2, 0);
    vec("br_over_lu", 0, 5, 0, 1, 0, 5, 1, 1, 0, 0, BR_C,  0, 2, 0);
    vec("after_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 2, 1);
    vec("br",         0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR_C,  0, 2, 1);
    vec("mem_fast",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM_C, 0, 2, 2);
    // memory wait of three cycles, then ready
    vec("rst_b",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_C, 0, 2, 2);
    vec("mw1",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 0, 0);
    vec("mw2",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 1, 0);
    vec("mw3",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 2, 0);
    vec("mw_ready",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM_C, 0, 3, 0);
    vec("mw4",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 3, 0);
    vec("mw_rdy_br",  0, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR_C,  0, 4, 0);
    vec("run_again",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 4, 1);
    // timeout to ERROR with MEM_TIMEOUT=4
    vec("rst_c",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_C, 0, 4, 1);
    vec("to_run",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 0, 0);
    vec("to_w0",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 1, 0);
    vec("to_w1",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 2, 0);
    vec("to_w2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 3, 0);
    vec("to_w3",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 4, 0);
    vec("to_w4",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 5, 0);
    vec("err",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 1, 6, 0);
    vec("err_sticky", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ_C, 1, 7, 0);
    vec("err_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_C, 0, 8, 0);
    vec("post_err",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 0, 0);
    // reset in the middle of a wait discards it
    vec("d_run",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 0, 0);
    vec("d_w0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_C, 0, 1, 0);
    vec("d_rst",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST_C, 0, 2, 0);
    vec("d_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 0, 0);
    // saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      vec("sat",      0, 5, 0, 1, 0, 5, 1, 0, 0, 0, LU_C,  0,
          (i > 15) ? 4'd15 : 4'(i), 0);
    end
    vec("sat_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM_C, 0, 15, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
